// File: rtl/ghazi_ram_pkg.sv
// Shared types and helpers for the DFFRAM arbiter.
package ghazi_ram_pkg;

  // Identifies a core requester: used as the round-robin pointer and the read-return tag.
  typedef enum logic [1:0] {
    PORT_NONE  = 2'd0,
    PORT_INSTR = 2'd1,
    PORT_DATA  = 2'd2
  } ram_port_e;

  // A byte lane is written when any bit of its mask byte is set.
  function automatic logic [3:0] wmask_to_we(input logic [31:0] wmask);
    logic [3:0] we;
    for (int i = 0; i < 4; i++) begin
      we[i] = |wmask[8*i +: 8];
    end
    return we;
  endfunction

endpackage

// File: rtl/ghazi_dffram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter between the core instruction and data ports.
module ghazi_rr_arb2
  import ghazi_ram_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic instr_req_i,
  input  logic data_req_i,
  output logic instr_gnt_o,
  output logic data_gnt_o
);

  ram_port_e rr_ptr_q, rr_ptr_d;

  // Grant selection: a lone requester wins; on contention the port not last favoured wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    instr_gnt_o = 1'b0;
    data_gnt_o  = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    if (en_i) begin
      if (instr_req_i && data_req_i) begin
        if (rr_ptr_q == PORT_DATA) begin
          instr_gnt_o = 1'b1;
          rr_ptr_d    = PORT_INSTR;
        end else begin
          data_gnt_o  = 1'b1;
          rr_ptr_d    = PORT_DATA;
        end
      end else begin
        instr_gnt_o = instr_req_i;
        data_gnt_o  = data_req_i;
      end
    end
  end

  // Pointer register; it moves only on a contested grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) rr_ptr_q <= PORT_INSTR;
    else         rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/ghazi_dffram_arbiter.sv
// Shares one single-port DFFRAM between the UART loader and the core instr/data ports.
module ghazi_dffram_arbiter
  import ghazi_ram_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             prog_mode_i,
  input  logic             prog_we_i,
  input  logic [13:0]      prog_addr_i,
  input  logic [DW-1:0]    prog_wdata_i,
  input  logic             instr_req_i,
  input  logic             instr_we_i,
  input  logic [13:0]      instr_addr_i,
  input  logic [DW-1:0]    instr_wdata_i,
  input  logic [DW-1:0]    instr_wmask_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  output logic [DW-1:0]    instr_rdata_o,
  input  logic             data_req_i,
  input  logic             data_we_i,
  input  logic [13:0]      data_addr_i,
  input  logic [DW-1:0]    data_wdata_i,
  input  logic [DW-1:0]    data_wmask_i,
  output logic             data_gnt_o,
  output logic             data_rvalid_o,
  output logic [DW-1:0]    data_rdata_o,
  output logic             ram_en_o,
  output logic [3:0]       ram_we_o,
  output logic [AW-1:0]    ram_a_o,
  output logic [DW-1:0]    ram_di_o,
  input  logic [DW-1:0]    ram_do_i,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  ram_port_e        tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_en;
  logic             conflict;

  // Address bits above AW are dropped on purpose.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{prog_addr_i[13:AW], instr_addr_i[13:AW], data_addr_i[13:AW]};

  // NOTE: reset also gates the combinational grant/enable path, so an access interrupted by reset never reaches the RAM.
  assign core_en  = rst_ni & ~prog_mode_i;
  assign conflict = ~prog_mode_i & instr_req_i & data_req_i;

  ghazi_rr_arb2 u_rr_arb2 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (core_en),
    .instr_req_i (instr_req_i),
    .data_req_i  (data_req_i),
    .instr_gnt_o (instr_gnt_o),
    .data_gnt_o  (data_gnt_o)
  );

  // RAM port mux and return-tag selection for the current cycle's owner.
  always_comb begin
    ram_en_o = 1'b0;
    ram_we_o = 4'b0000;
    ram_a_o  = '0;
    ram_di_o = '0;
    tag_d    = PORT_NONE;
    if (prog_mode_i) begin
      ram_en_o = prog_we_i & rst_ni;
      ram_we_o = {4{prog_we_i & rst_ni}};
      ram_a_o  = prog_addr_i[AW-1:0];
      ram_di_o = prog_wdata_i;
    end else if (instr_gnt_o) begin
      ram_en_o = 1'b1;
      ram_we_o = {4{instr_we_i}} & wmask_to_we(instr_wmask_i);
      ram_a_o  = instr_addr_i[AW-1:0];
      ram_di_o = instr_wdata_i;
      tag_d    = instr_we_i ? PORT_NONE : PORT_INSTR;
    end else if (data_gnt_o) begin
      ram_en_o = 1'b1;
      ram_we_o = {4{data_we_i}} & wmask_to_we(data_wmask_i);
      ram_a_o  = data_addr_i[AW-1:0];
      ram_di_o = data_wdata_i;
      tag_d    = data_we_i ? PORT_NONE : PORT_DATA;
    end
  end

  // Saturating count of contested cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (conflict && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Return tag and conflict counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q <= PORT_NONE;
      cnt_q <= '0;
    end else begin
      tag_q <= tag_d;
      cnt_q <= cnt_d;
    end
  end

  assign instr_rvalid_o = (tag_q == PORT_INSTR);
  assign data_rvalid_o  = (tag_q == PORT_DATA);
  assign instr_rdata_o  = ram_do_i;
  assign data_rdata_o   = ram_do_i;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_ghazi_dffram_arbiter.sv
// Self-checking bench for ghazi_dffram_arbiter with a behavioural DFFRAM and read-return scoreboard.
module tb_ghazi_dffram_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int CNT_W = 16;

  logic             clk, rst_n;
  logic             prog_mode, prog_we;
  logic [13:0]      prog_addr;
  logic [DW-1:0]    prog_wdata;
  logic             instr_req, instr_we, instr_gnt, instr_rvalid;
  logic [13:0]      instr_addr;
  logic [DW-1:0]    instr_wdata, instr_wmask, instr_rdata;
  logic             data_req, data_we, data_gnt, data_rvalid;
  logic [13:0]      data_addr;
  logic [DW-1:0]    data_wdata, data_wmask, data_rdata;
  logic             ram_en;
  logic [3:0]       ram_we;
  logic [AW-1:0]    ram_a;
  logic [DW-1:0]    ram_di, ram_do;
  logic [CNT_W-1:0] conflict_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_instr_q [$];
  logic [31:0] exp_data_q  [$];

  ghazi_dffram_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .prog_mode_i(prog_mode), .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata),
    .instr_req_i(instr_req), .instr_we_i(instr_we), .instr_addr_i(instr_addr),
    .instr_wdata_i(instr_wdata), .instr_wmask_i(instr_wmask),
    .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_wmask_i(data_wmask),
    .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_a_o(ram_a), .ram_di_o(ram_di), .ram_do_i(ram_do),
    .conflict_cnt_o(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DFFRAM: byte-lane writes, registered read data on enabled reads.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++) if (ram_we[i]) mem[ram_a][8*i +: 8] <= ram_di[8*i +: 8];
      if (ram_we == 4'b0000) ram_do <= mem[ram_a];
    end
  end

  // Scoreboard: every rvalid must match the oldest expected word for that port.
  always @(negedge clk) begin
    if (instr_rvalid) begin
      checks++;
      if (exp_instr_q.size() == 0) begin
        failures++; $display("FAIL instr_rvalid_unexpected got=1 exp=0 t=%0t", $time);
      end else begin
        logic [31:0] e;
        e = exp_instr_q.pop_front();
        if (instr_rdata !== e) begin
          failures++; $display("FAIL instr_rdata got=%h exp=%h t=%0t", instr_rdata, e, $time);
        end
      end
    end
    if (data_rvalid) begin
      checks++;
      if (exp_data_q.size() == 0) begin
        failures++; $display("FAIL data_rvalid_unexpected got=1 exp=0 t=%0t", $time);
      end else begin
        logic [31:0] e;
        e = exp_data_q.pop_front();
        if (data_rdata !== e) begin
          failures++; $display("FAIL data_rdata got=%h exp=%h t=%0t", data_rdata, e, $time);
        end
      end
    end
  end

  function automatic logic [31:0] pattern(int i);
    return 32'hA5000000 ^ (32'(i) * 32'h00010203);
  endfunction

  function automatic void ref_write(int a, logic [31:0] wd, logic [31:0] wm);
    ref_mem[a] = (ref_mem[a] & ~wm) | (wd & wm);
  endfunction

  task automatic idle();
    prog_mode = 0; prog_we = 0; prog_addr = '0; prog_wdata = '0;
    instr_req = 0; instr_we = 0; instr_addr = '0; instr_wdata = '0; instr_wmask = '0;
    data_req = 0; data_we = 0; data_addr = '0; data_wdata = '0; data_wmask = '0;
  endtask

  task automatic drain(string name);
    @(negedge clk);
    idle();
    #2;
    checks++;
    if (exp_instr_q.size() != 0 || exp_data_q.size() != 0) begin
      failures++;
      $display("FAIL %s_pending_returns got=%0d/%0d exp=0/0", name, exp_instr_q.size(), exp_data_q.size());
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    instr_req = 1; data_req = 1;
    #2;
    checks++;
    if ({instr_gnt, data_gnt, instr_rvalid, data_rvalid, ram_en, ram_we} !== 9'b0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0", {instr_gnt, data_gnt, instr_rvalid, data_rvalid, ram_en, ram_we});
    end
    checks++;
    if (conflict_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", conflict_cnt); end
    @(negedge clk);
    idle();
    rst_n = 1;
  endtask

  task automatic test_instr_read();
    @(negedge clk);
    instr_req = 1; instr_addr = 14'h005;
    #1;
    checks++;
    if ({instr_gnt, data_gnt, ram_en, ram_we, ram_a} !== {3'b101, 4'b0000, 8'h05}) begin
      failures++; $display("FAIL instr_read_grant got=%b/%b/%b/%h/%h exp=1/0/1/0/05", instr_gnt, data_gnt, ram_en, ram_we, ram_a);
    end
    exp_instr_q.push_back(ref_mem[5]);
    @(negedge clk);
    idle();
    checks++;
    if (instr_rvalid !== 1'b1) begin failures++; $display("FAIL instr_rvalid got=%b exp=1", instr_rvalid); end
    drain("instr_read");
  endtask

  task automatic test_data_write();
    @(negedge clk);
    data_req = 1; data_we = 1; data_addr = 14'h010; data_wdata = 32'hDEADBEEF; data_wmask = 32'h0000FF00;
    #1;
    checks++;
    if ({data_gnt, ram_en, ram_we, ram_a, ram_di} !== {2'b11, 4'b0010, 8'h10, 32'hDEADBEEF}) begin
      failures++; $display("FAIL data_write got=%b/%b/%b/%h/%h exp=1/1/0010/10/deadbeef", data_gnt, ram_en, ram_we, ram_a, ram_di);
    end
    ref_write(16, 32'hDEADBEEF, 32'h0000FF00);
    @(negedge clk);
    checks++;
    if (data_rvalid !== 1'b0) begin failures++; $display("FAIL data_write_rvalid got=%b exp=0", data_rvalid); end
    data_we = 0; data_wdata = '0; data_wmask = '0;
    #1;
    exp_data_q.push_back(ref_mem[16]);
    checks++;
    if (ref_mem[16][15:8] !== 8'hBE || ref_mem[16][31:16] !== pattern(16)[31:16]) begin
      failures++; $display("FAIL data_write_ref got=%h exp=lane1 BE", ref_mem[16]);
    end
    drain("data_write");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      data_req = 1; data_addr = 14'(16 + k);
      #1;
      checks++;
      if (data_gnt !== 1'b1 || ram_a !== 8'(16 + k)) begin
        failures++; $display("FAIL b2b_grant%0d got=%b/%h exp=1/%h", k, data_gnt, ram_a, 8'(16 + k));
      end
      exp_data_q.push_back(ref_mem[16 + k]);
      if (k > 0) begin
        checks++;
        if (data_rvalid !== 1'b1) begin failures++; $display("FAIL b2b_rvalid%0d got=%b exp=1", k, data_rvalid); end
      end
    end
    drain("back_to_back");
  endtask

  task automatic test_contention();
    int ia, da;
    ia = 0; da = 0;
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      bit exp_d;
      if (k > 0) @(negedge clk);
      instr_req = 1; instr_addr = 14'(32 + ia);
      data_req = 1;  data_addr  = 14'(48 + da);
      #1;
      exp_d = (k % 2 == 0);
      checks++;
      if (instr_gnt !== !exp_d || data_gnt !== exp_d) begin
        failures++; $display("FAIL contention_grant%0d got=i%b/d%b exp_data=%b", k, instr_gnt, data_gnt, exp_d);
      end
      checks++;
      if (ram_a !== (exp_d ? 8'(48 + da) : 8'(32 + ia))) begin
        failures++; $display("FAIL contention_addr%0d got=%h", k, ram_a);
      end
      if (exp_d) begin exp_data_q.push_back(ref_mem[48 + da]); da++; end
      else       begin exp_instr_q.push_back(ref_mem[32 + ia]); ia++; end
    end
    @(negedge clk);
    idle();
    checks++;
    if (conflict_cnt !== 16'd4) begin failures++; $display("FAIL contention_cnt got=%0d exp=4", conflict_cnt); end
    drain("contention");
  endtask

  task automatic test_prog_mode();
    logic [CNT_W-1:0] cnt_before;
    @(negedge clk);
    instr_req = 1; instr_addr = 14'h007;
    exp_instr_q.push_back(ref_mem[7]);
    @(negedge clk);
    checks++;
    if (instr_rvalid !== 1'b1) begin failures++; $display("FAIL prog_rise_rvalid got=%b exp=1", instr_rvalid); end
    cnt_before = conflict_cnt;
    prog_mode = 1; prog_we = 1; prog_addr = 14'h3FF; prog_wdata = 32'h12345678;
    instr_req = 1; instr_addr = 14'h008; data_req = 1; data_addr = 14'h009;
    #1;
    checks++;
    if ({instr_gnt, data_gnt, ram_en, ram_we, ram_a, ram_di} !== {3'b001, 4'hF, 8'hFF, 32'h12345678}) begin
      failures++; $display("FAIL prog_write got=%b/%b/%b/%h/%h/%h exp=0/0/1/f/ff/12345678", instr_gnt, data_gnt, ram_en, ram_we, ram_a, ram_di);
    end
    ref_mem[255] = 32'h12345678;
    @(negedge clk);
    prog_we = 0;
    #1;
    checks++;
    if ({instr_gnt, data_gnt, ram_en, ram_we} !== 7'b0) begin
      failures++; $display("FAIL prog_idle got=%b exp=0", {instr_gnt, data_gnt, ram_en, ram_we});
    end
    checks++;
    if (conflict_cnt !== cnt_before) begin failures++; $display("FAIL prog_cnt got=%0d exp=%0d", conflict_cnt, cnt_before); end
    @(negedge clk);
    idle();
    instr_req = 1; instr_addr = 14'h0FF;
    #1;
    exp_instr_q.push_back(ref_mem[255]);
    drain("prog_mode");
  endtask

  task automatic test_saturation();
    pulse_reset();
    instr_req = 1; instr_we = 1; instr_addr = 14'h020; instr_wdata = 32'hCAFEF00D; instr_wmask = '1;
    data_req = 1;  data_we = 1;  data_addr = 14'h020;  data_wdata = 32'hCAFEF00D;  data_wmask = '1;
    ref_mem[32] = 32'hCAFEF00D;
    repeat (65534) @(negedge clk);
    checks++;
    if (conflict_cnt !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=fffe", conflict_cnt); end
    @(negedge clk);
    checks++;
    if (conflict_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hit got=%h exp=ffff", conflict_cnt); end
    repeat (4) @(negedge clk);
    checks++;
    if (conflict_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", conflict_cnt); end
    drain("saturation");
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    instr_req = 1; instr_addr = 14'h005;
    #1;
    checks++;
    if (instr_gnt !== 1'b1) begin failures++; $display("FAIL midrst_grant got=%b exp=1", instr_gnt); end
    #1;
    rst_n = 0;
    #1;
    checks++;
    if ({instr_gnt, ram_en, ram_we} !== 6'b0) begin failures++; $display("FAIL midrst_en got=%b exp=0", {instr_gnt, ram_en, ram_we}); end
    @(negedge clk);
    checks++;
    if (instr_rvalid !== 1'b0 || data_rvalid !== 1'b0) begin
      failures++; $display("FAIL midrst_rvalid got=%b%b exp=00", instr_rvalid, data_rvalid);
    end
    idle();
    rst_n = 1;
    #1;
    checks++;
    if (conflict_cnt !== '0) begin failures++; $display("FAIL midrst_cnt got=%h exp=0", conflict_cnt); end
    instr_req = 1; instr_addr = 14'h040; data_req = 1; data_addr = 14'h041;
    #1;
    checks++;
    if (instr_gnt !== 1'b0 || data_gnt !== 1'b1) begin
      failures++; $display("FAIL midrst_rrptr got=i%b/d%b exp=i0/d1", instr_gnt, data_gnt);
    end
    exp_data_q.push_back(ref_mem[65]);
    drain("reset_mid_access");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = pattern(i);
      ref_mem[i] = pattern(i);
    end
    ram_do = '0;
    test_reset();
    test_instr_read();
    test_data_write();
    test_back_to_back();
    test_contention();
    test_prog_mode();
    test_saturation();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
